pc_fetch_unit: RTL and testbench

//  Fetch-stage program counter for the MIPS pipeline. Replaces the plain PC <= npc latch with a

---
 rtl/pc_fetch_pkg.sv | 18 +
 rtl/pc_next_mux.sv | 42 ++++
 rtl/pc_fetch_unit.sv | 86 ++++++++
 tb/tb_pc_fetch_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types for the fetch-stage program counter: FSM state and next-pc source select.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_INC   = 3'd1,
    SEL_REDIR = 3'd2,
    SEL_PEND  = 3'd3,
    SEL_TRAP  = 3'd4
  } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational priority select of the next fetch pc.
module pc_next_mux
  import pc_fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  fetch_state_t     state,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic             trap,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic [WIDTH-1:0] pend_tgt,
  input  logic [WIDTH-1:0] trap_pc,
  output pc_sel_t          sel,
  output logic [WIDTH-1:0] next_pc
);

  // A redirect arriving under stall holds pc; the top captures it into pend_tgt.
  always_comb begin
    sel = SEL_HOLD;
    if (state == BOOT)                 sel = SEL_HOLD;
    else if (trap)                     sel = SEL_TRAP;
    else if (redirect_valid && !stall) sel = SEL_REDIR;
    else if (state == PEND && !stall)  sel = SEL_PEND;
    else if (stall)                    sel = SEL_HOLD;
    else                               sel = SEL_INC;
  end

  always_comb begin
    next_pc = pc;
    case (sel)
      SEL_INC:   next_pc = npc;
      SEL_REDIR: next_pc = redirect_target;
      SEL_PEND:  next_pc = pend_tgt;
      SEL_TRAP:  next_pc = trap_pc;
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC: sequential step, stall, redirect, trap, and redirect capture while stalled.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          PC_STEP   = 1,
  parameter logic [31:0] RESET_VEC = 32'h0,
  parameter logic [31:0] TRAP_VEC  = 32'h80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             pc_valid,
  output logic             flush,
  output logic             redirect_pending
);

  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VEC);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);

  fetch_state_t     state, state_nxt;
  pc_sel_t          sel;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] pend_tgt;
  logic             capture;

  assign npc     = pc + STEP;
  assign capture = (state != BOOT) && !trap && redirect_valid && stall;

  pc_next_mux #(.WIDTH(WIDTH)) u_mux (
    .state           (state),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .trap            (trap),
    .pc              (pc),
    .npc             (npc),
    .redirect_target (redirect_target),
    .pend_tgt        (pend_tgt),
    .trap_pc         (TRAP_PC),
    .sel             (sel),
    .next_pc         (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, PEND: begin
        if (trap)                              state_nxt = RUN;
        else if (redirect_valid && !stall)     state_nxt = RUN;
        else if (redirect_valid && stall)      state_nxt = PEND;
        else if (state == PEND && !stall)      state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    pc_valid         = (state != BOOT);
    redirect_pending = (state == PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RST_PC;
      pend_tgt <= '0;
      flush    <= 1'b0;
    end else begin
      pc    <= next_pc;
      flush <= (sel == SEL_REDIR) || (sel == SEL_PEND) || (sel == SEL_TRAP);
      if (capture) pend_tgt <= redirect_target;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed checks of the fetch PC: boot, redirect, stall capture, trap, wrap, async reset.
module tb_pc_fetch_unit;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        stall = 0, redirect_valid = 0, trap = 0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc, npc;
  logic        pc_valid, flush, redirect_pending;

  logic        stall8 = 0, redir8 = 0, trap8 = 0;
  logic [7:0]  tgt8 = '0;
  logic [7:0]  pc8, npc8;
  logic        valid8, flush8, pend8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap(trap), .pc(pc), .npc(npc),
    .pc_valid(pc_valid), .flush(flush), .redirect_pending(redirect_pending)
  );

  pc_fetch_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .stall(stall8), .redirect_valid(redir8),
    .redirect_target(tgt8), .trap(trap8), .pc(pc8), .npc(npc8),
    .pc_valid(valid8), .flush(flush8), .redirect_pending(pend8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
    total++; if (pc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
    total++; if (flush !== 1'b0 || redirect_pending !== 1'b0) begin bad++; $display("FAIL reset_flags flush=%b pend=%b exp=0,0", flush, redirect_pending); end
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (pc !== 32'(i)) begin bad++; $display("FAIL boot_seq%0d got=%h exp=%h", i, pc, i); end
      total++; if (pc_valid !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL boot_flags%0d valid=%b flush=%b exp=1,0", i, pc_valid, flush); end
    end
  endtask

  task automatic test_redirect();
    tick(); tick();
    total++; if (pc !== 32'd5) begin bad++; $display("FAIL inc_to5 got=%h exp=5", pc); end
    redirect_valid = 1; redirect_target = 32'h40;
    tick();
    total++; if (pc !== 32'h40 || flush !== 1'b1) begin bad++; $display("FAIL redir pc=%h flush=%b exp=40,1", pc, flush); end
    redirect_valid = 0;
    tick();
    total++; if (pc !== 32'h41 || flush !== 1'b0) begin bad++; $display("FAIL redir_after pc=%h flush=%b exp=41,0", pc, flush); end
  endtask

  task automatic test_stall_pending();
    redirect_valid = 1; redirect_target = 32'h7;
    tick();
    stall = 1; redirect_target = 32'h20;
    tick();
    total++; if (pc !== 32'h7 || redirect_pending !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL capture pc=%h pend=%b flush=%b exp=7,1,0", pc, redirect_pending, flush); end
    total++; if (npc !== 32'h8) begin bad++; $display("FAIL npc_stalled got=%h exp=8", npc); end
    redirect_valid = 0;
    tick();
    total++; if (pc !== 32'h7 || redirect_pending !== 1'b1) begin bad++; $display("FAIL pend_hold pc=%h pend=%b exp=7,1", pc, redirect_pending); end
    stall = 0;
    tick();
    total++; if (pc !== 32'h20 || flush !== 1'b1 || redirect_pending !== 1'b0) begin bad++; $display("FAIL pend_release pc=%h flush=%b pend=%b exp=20,1,0", pc, flush, redirect_pending); end
    tick();
    total++; if (pc !== 32'h21 || flush !== 1'b0) begin bad++; $display("FAIL pend_after pc=%h flush=%b exp=21,0", pc, flush); end
  endtask

  task automatic test_trap();
    stall = 1; redirect_valid = 1; redirect_target = 32'h20;
    tick();
    total++; if (pc !== 32'h21 || redirect_pending !== 1'b1) begin bad++; $display("FAIL trap_setup pc=%h pend=%b exp=21,1", pc, redirect_pending); end
    redirect_valid = 0; trap = 1;
    tick();
    total++; if (pc !== 32'h80 || redirect_pending !== 1'b0 || flush !== 1'b1) begin bad++; $display("FAIL trap pc=%h pend=%b flush=%b exp=80,0,1", pc, redirect_pending, flush); end
    trap = 0; stall = 0;
    tick();
    total++; if (pc !== 32'h81 || flush !== 1'b0) begin bad++; $display("FAIL trap_after pc=%h flush=%b exp=81,0", pc, flush); end
  endtask

  task automatic test_back_to_back();
    stall = 1; redirect_valid = 1; redirect_target = 32'h20;
    tick();
    redirect_target = 32'h30;
    tick();
    total++; if (pc !== 32'h81 || redirect_pending !== 1'b1) begin bad++; $display("FAIL overwrite_hold pc=%h pend=%b exp=81,1", pc, redirect_pending); end
    redirect_valid = 0; stall = 0;
    tick();
    total++; if (pc !== 32'h30 || flush !== 1'b1) begin bad++; $display("FAIL overwrite pc=%h flush=%b exp=30,1", pc, flush); end
    stall = 1; redirect_valid = 1; redirect_target = 32'h60;
    tick();
    stall = 0; redirect_target = 32'h50;
    tick();
    total++; if (pc !== 32'h50 || redirect_pending !== 1'b0 || flush !== 1'b1) begin bad++; $display("FAIL redir_over_pend pc=%h pend=%b flush=%b exp=50,0,1", pc, redirect_pending, flush); end
    redirect_valid = 0;
    tick();
    total++; if (pc !== 32'h51) begin bad++; $display("FAIL redir_over_after got=%h exp=51", pc); end
  endtask

  task automatic test_wrap8();
    redir8 = 1; tgt8 = 8'hFF;
    tick();
    total++; if (pc8 !== 8'hFF || npc8 !== 8'h00) begin bad++; $display("FAIL w8_ff pc=%h npc=%h exp=ff,00", pc8, npc8); end
    redir8 = 0;
    tick();
    total++; if (pc8 !== 8'h00 || npc8 !== 8'h01) begin bad++; $display("FAIL w8_wrap pc=%h npc=%h exp=00,01", pc8, npc8); end
    trap8 = 1;
    tick();
    total++; if (pc8 !== 8'h80 || flush8 !== 1'b1) begin bad++; $display("FAIL w8_trap pc=%h flush=%b exp=80,1", pc8, flush8); end
    trap8 = 0;
  endtask

  task automatic test_async_reset();
    stall = 1; redirect_valid = 1; redirect_target = 32'h20;
    tick();
    total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL ar_setup pend=%b exp=1", redirect_pending); end
    #2 rst_n = 0;
    #1;
    total++; if (pc !== 32'h0 || redirect_pending !== 1'b0 || pc_valid !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL async_rst pc=%h pend=%b valid=%b flush=%b exp=0,0,0,0", pc, redirect_pending, pc_valid, flush); end
    tick();
    rst_n = 1; stall = 0; redirect_target = 32'h55;
    tick();
    total++; if (pc !== 32'h0 || pc_valid !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL boot_ignore pc=%h valid=%b flush=%b exp=0,1,0", pc, pc_valid, flush); end
    redirect_valid = 0;
    tick();
    total++; if (pc !== 32'h1) begin bad++; $display("FAIL post_rst_inc got=%h exp=1", pc); end
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_stall_pending();
    test_trap();
    test_back_to_back();
    test_wrap8();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
